// File: rtl/ftdi_tx_writer.sv
// Host-bound write path of the FTDI 16-bit synchronous FIFO interface.
// Buffers user words and auto-generated FPGA status words, then drains them
// to the FTDI chip under the TXE#/WR# handshake, yielding the bus to the read
// path whenever rd_busy is high while idle.
module ftdi_tx_writer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MAX_BURST  = 16,
  parameter logic [3:0]  STATUS_TAG = 4'hA
) (
  input  logic        ftdi_clk,
  input  logic        rst,
  input  logic        tx_valid,
  input  logic [15:0] tx_data,
  output logic        tx_ready,
  input  logic        fpga_done,
  input  logic        fpga_init_b,
  input  logic        ftdi_txe_n,
  input  logic        rd_busy,
  output logic        ftdi_wr_n,
  output logic [15:0] ftdi_data_out,
  output logic        ftdi_data_oe,
  output logic        tx_busy,
  output logic        overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {StIdle, StTurn, StWrite, StRelease} state_e;

  // Synchronizer and status tracking
  logic       done_meta, done_s, init_meta, init_s;
  logic       status_pending, overflow_q;
  logic [7:0] seq;
  logic       status_event, enq_status;
  logic [15:0] status_word;

  // FIFO
  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_next;
  logic [CW-1:0] count;
  logic          full, empty, push, push_user, pop;
  logic [15:0]   push_data, head, next_head;

  // FSM and bus registers
  state_e        state_q, state_d;
  logic          wr_n_q, wr_n_d, oe_q, oe_d;
  logic [15:0]   data_q, data_d;
  logic [BW-1:0] burst_q, burst_d;
  logic          last_word, burst_hit;

  // Two-flop synchronizers for the asynchronous FPGA pins
  always_ff @(posedge ftdi_clk or posedge rst) begin
    if (rst) begin
      done_meta <= 1'b0;
      done_s    <= 1'b0;
      init_meta <= 1'b0;
      init_s    <= 1'b0;
    end else begin
      done_meta <= fpga_done;
      done_s    <= done_meta;
      init_meta <= fpga_init_b;
      init_s    <= init_meta;
    end
  end

  // A change is seen on the edge where the synced bit takes its new value
  assign status_event = (done_meta != done_s) || (init_meta != init_s);
  assign full         = (count == CW'(FIFO_DEPTH));
  assign empty        = (count == '0);
  assign enq_status   = status_pending && !full;
  assign tx_ready     = !full && !status_pending;
  assign push_user    = tx_valid && tx_ready;
  assign push         = enq_status || push_user;
  assign status_word  = {STATUS_TAG, 2'b00, done_s, init_s, seq};
  assign push_data    = enq_status ? status_word : tx_data;

  // Status pending flag, sticky overflow and status sequence number
  always_ff @(posedge ftdi_clk or posedge rst) begin
    if (rst) begin
      status_pending <= 1'b0;
      overflow_q     <= 1'b0;
      seq            <= 8'd0;
    end else begin
      status_pending <= status_event || (status_pending && !enq_status);
      // A new change while an older one still waits means an event was merged
      if (status_event && status_pending && !enq_status) overflow_q <= 1'b1;
      if (enq_status) seq <= seq + 8'd1;
    end
  end

  // FIFO storage, no reset needed
  always_ff @(posedge ftdi_clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge ftdi_clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign rd_next = rd_ptr + AW'(1);
  assign head    = mem[rd_ptr];
  // With one word left, a same-cycle push becomes the next head
  assign next_head = (count == CW'(1)) ? push_data : mem[rd_next];
  assign last_word = (count == CW'(1)) && !push;
  assign burst_hit = (burst_q == BW'(MAX_BURST - 1));

  // FSM state and registered bus outputs
  always_ff @(posedge ftdi_clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      wr_n_q  <= 1'b1;
      oe_q    <= 1'b0;
      data_q  <= 16'h0000;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      wr_n_q  <= wr_n_d;
      oe_q    <= oe_d;
      data_q  <= data_d;
      burst_q <= burst_d;
    end
  end

  // Next-state logic and FIFO pop
  always_comb begin
    state_d = state_q;
    wr_n_d  = wr_n_q;
    oe_d    = oe_q;
    data_d  = data_q;
    burst_d = burst_q;
    pop     = 1'b0;
    case (state_q)
      StIdle: begin
        if (!empty && !ftdi_txe_n && !rd_busy) begin
          state_d = StTurn;
          oe_d    = 1'b1;
          wr_n_d  = 1'b1;
          data_d  = head;
        end
      end
      StTurn: begin
        state_d = StWrite;
        wr_n_d  = 1'b0;
      end
      StWrite: begin
        if (!wr_n_q && !ftdi_txe_n) begin
          pop     = 1'b1;
          burst_d = burst_q + BW'(1);
          data_d  = next_head;
          if (last_word || burst_hit) begin
            wr_n_d  = 1'b1;
            state_d = StRelease;
          end
        end
      end
      StRelease: begin
        oe_d    = 1'b0;
        wr_n_d  = 1'b1;
        burst_d = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign ftdi_wr_n     = wr_n_q;
  assign ftdi_data_oe  = oe_q;
  assign ftdi_data_out = data_q;
  assign tx_busy       = (state_q != StIdle);
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_ftdi_tx_writer.sv
// Directed testbench for ftdi_tx_writer with hand-computed expectations.
module tb_ftdi_tx_writer;

  logic        ftdi_clk = 1'b0;
  logic        rst;
  logic        tx_valid;
  logic [15:0] tx_data;
  logic        tx_ready;
  logic        fpga_done;
  logic        fpga_init_b;
  logic        ftdi_txe_n;
  logic        rd_busy;
  logic        ftdi_wr_n;
  logic [15:0] ftdi_data_out;
  logic        ftdi_data_oe;
  logic        tx_busy;
  logic        overflow;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] got[$];
  logic [15:0] exp_q[$];
  int          bursts[$];
  int          cur_burst = 0;

  ftdi_tx_writer dut (
    .ftdi_clk      (ftdi_clk),
    .rst           (rst),
    .tx_valid      (tx_valid),
    .tx_data       (tx_data),
    .tx_ready      (tx_ready),
    .fpga_done     (fpga_done),
    .fpga_init_b   (fpga_init_b),
    .ftdi_txe_n    (ftdi_txe_n),
    .rd_busy       (rd_busy),
    .ftdi_wr_n     (ftdi_wr_n),
    .ftdi_data_out (ftdi_data_out),
    .ftdi_data_oe  (ftdi_data_oe),
    .tx_busy       (tx_busy),
    .overflow      (overflow)
  );

  always #5 ftdi_clk = ~ftdi_clk;

  // Capture every word the FTDI chip accepts and the length of each bus ownership
  always @(posedge ftdi_clk) begin
    if (!ftdi_wr_n && !ftdi_txe_n) begin
      got.push_back(ftdi_data_out);
      cur_burst <= cur_burst + 1;
    end else if (!ftdi_data_oe && cur_burst != 0) begin
      bursts.push_back(cur_burst);
      cur_burst <= 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_got(input string tag, input int base);
    chk({tag, "_count"}, 32'(got.size() - base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < got.size()) chk(tag, 32'(got[base + i]), 32'(exp_q[i]));
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge ftdi_clk);
      #1;
    end
  endtask

  initial begin
    int base;
    int bbase;
    int pushed;
    int cyc;
    logic acc;

    rst = 1'b1; tx_valid = 1'b0; tx_data = 16'h0; fpga_done = 1'b0;
    fpga_init_b = 1'b0; ftdi_txe_n = 1'b1; rd_busy = 1'b0;
    tick(2);
    chk("rst_wr_n", 32'(ftdi_wr_n), 32'd1);
    chk("rst_oe", 32'(ftdi_data_oe), 32'd0);
    chk("rst_data", 32'(ftdi_data_out), 32'h0);
    chk("rst_busy", 32'(tx_busy), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    rst = 1'b0;
    tick(1);
    chk("rst_ready", 32'(tx_ready), 32'd1);

    // Test 1: three back-to-back words
    base = got.size();
    ftdi_txe_n = 1'b0;
    tx_valid = 1'b1; tx_data = 16'h1111;
    tick(1);
    tx_data = 16'h2222;
    tick(1);
    chk("t1_turn_oe", 32'(ftdi_data_oe), 32'd1);
    chk("t1_turn_wr_n", 32'(ftdi_wr_n), 32'd1);
    chk("t1_turn_data", 32'(ftdi_data_out), 32'h1111);
    chk("t1_turn_busy", 32'(tx_busy), 32'd1);
    tx_data = 16'h3333;
    tick(1);
    tx_valid = 1'b0;
    chk("t1_write_wr_n", 32'(ftdi_wr_n), 32'd0);
    chk("t1_write_data0", 32'(ftdi_data_out), 32'h1111);
    tick(1);
    chk("t1_write_data1", 32'(ftdi_data_out), 32'h2222);
    tick(1);
    chk("t1_write_data2", 32'(ftdi_data_out), 32'h3333);
    chk("t1_wr_n_low2", 32'(ftdi_wr_n), 32'd0);
    tick(1);
    chk("t1_end_wr_n", 32'(ftdi_wr_n), 32'd1);
    chk("t1_end_oe", 32'(ftdi_data_oe), 32'd1);
    tick(1);
    chk("t1_rel_oe", 32'(ftdi_data_oe), 32'd0);
    chk("t1_rel_busy", 32'(tx_busy), 32'd0);
    exp_q = {16'h1111, 16'h2222, 16'h3333};
    check_got("t1_words", base);

    // Test 2: TXE# high mid-burst
    base = got.size();
    tx_valid = 1'b1; tx_data = 16'h4444;
    tick(1);
    tx_data = 16'h5555;
    tick(1);
    tx_data = 16'h6666;
    tick(1);
    tx_valid = 1'b0;
    tick(1);
    ftdi_txe_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick(1);
      chk("t2_hold_wr_n", 32'(ftdi_wr_n), 32'd0);
      chk("t2_hold_data", 32'(ftdi_data_out), 32'h5555);
    end
    chk("t2_hold_count", 32'(got.size() - base), 32'd1);
    ftdi_txe_n = 1'b0;
    tick(4);
    chk("t2_idle", 32'(tx_busy), 32'd0);
    exp_q = {16'h4444, 16'h5555, 16'h6666};
    check_got("t2_words", base);

    // Test 3: full FIFO, merged status events, status word after data
    base = got.size();
    ftdi_txe_n = 1'b1;
    tx_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tx_data = 16'h7001 + 16'(k);
      tick(1);
    end
    tx_valid = 1'b0;
    chk("t3_full_ready", 32'(tx_ready), 32'd0);
    fpga_done = 1'b1;
    tick(2);
    chk("t3_ovf_first", 32'(overflow), 32'd0);
    fpga_done = 1'b0;
    tick(2);
    chk("t3_ovf_set", 32'(overflow), 32'd1);
    ftdi_txe_n = 1'b0;
    tick(12);
    chk("t3_ovf_sticky", 32'(overflow), 32'd1);
    exp_q = {16'h7001, 16'h7002, 16'h7003, 16'h7004, 16'hA000};
    check_got("t3_words", base);

    // Test 4: 20 words split into bursts of 16 and 4; rd_busy blocks start
    base = got.size();
    bbase = bursts.size();
    rd_busy = 1'b1;
    tx_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tx_data = 16'h8000 + 16'(k);
      tick(1);
    end
    tx_valid = 1'b0;
    tick(5);
    chk("t4_blocked_busy", 32'(tx_busy), 32'd0);
    chk("t4_blocked_oe", 32'(ftdi_data_oe), 32'd0);
    chk("t4_blocked_ready", 32'(tx_ready), 32'd0);
    rd_busy = 1'b0;
    pushed = 4;
    cyc = 0;
    while (pushed < 20 && cyc < 200) begin
      tx_valid = 1'b1;
      tx_data = 16'h8000 + 16'(pushed);
      acc = tx_ready;
      tick(1);
      if (acc) pushed++;
      cyc++;
    end
    tx_valid = 1'b0;
    chk("t4_pushed", 32'(pushed), 32'd20);
    tick(30);
    exp_q.delete();
    for (int k = 0; k < 20; k++) exp_q.push_back(16'h8000 + 16'(k));
    check_got("t4_words", base);
    chk("t4_nbursts", 32'(bursts.size() - bbase), 32'd2);
    if (bursts.size() >= bbase + 2) begin
      chk("t4_burst0", 32'(bursts[bbase]), 32'd16);
      chk("t4_burst1", 32'(bursts[bbase + 1]), 32'd4);
    end

    // Test 5: status word wins over a waiting user word
    rst = 1'b1;
    #1;
    chk("t5_rst_ovf", 32'(overflow), 32'd0);
    tick(1);
    rst = 1'b0;
    tick(1);
    base = got.size();
    fpga_init_b = 1'b1;
    tick(2);
    chk("t5_pending_ready", 32'(tx_ready), 32'd0);
    tx_valid = 1'b1; tx_data = 16'hBEEF;
    tick(1);
    chk("t5_after_status_ready", 32'(tx_ready), 32'd1);
    tick(1);
    tx_valid = 1'b0;
    tick(8);
    exp_q = {16'hA100, 16'hBEEF};
    check_got("t5_words", base);

    // Test 6: reset in WRITE
    tx_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tx_data = 16'hCA01 + 16'(k);
      tick(1);
    end
    tx_valid = 1'b0;
    ftdi_txe_n = 1'b1;
    chk("t6_in_write", 32'(ftdi_wr_n), 32'd0);
    base = got.size();
    #2;
    rst = 1'b1;
    fpga_init_b = 1'b0;
    #1;
    chk("t6_rst_wr_n", 32'(ftdi_wr_n), 32'd1);
    chk("t6_rst_oe", 32'(ftdi_data_oe), 32'd0);
    chk("t6_rst_busy", 32'(tx_busy), 32'd0);
    chk("t6_rst_data", 32'(ftdi_data_out), 32'h0);
    tick(1);
    rst = 1'b0;
    ftdi_txe_n = 1'b0;
    tick(10);
    chk("t6_nothing_sent", 32'(got.size() - base), 32'd0);
    chk("t6_idle", 32'(tx_busy), 32'd0);
    chk("t6_ready", 32'(tx_ready), 32'd1);
    fpga_done = 1'b1;
    tick(10);
    exp_q = {16'hA200};
    check_got("t6_seq_restart", base);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
